// File: rtl/nibble_parity_receiver_if.sv
// ---------------------------------------------------------------------------
// nibble_parity_receiver_if
// Bundles the serial-frame request/data lines and the assembled-nibble
// results that pass between a frame source and the nibble parity receiver.
//
//   start       source -> rx : one-cycle request to open a frame
//   bit_in      source -> rx : serial data / parity bit
//   bit_valid   source -> rx : qualifies bit_in for one clock
//   data_out    rx -> source : last completed nibble (4 parallel lines)
//   parity_out  rx -> source : parity regenerated from data_out
//   parity_err  rx -> source : received parity disagreed on last frame
//   frame_valid rx -> source : one-cycle pulse, results just updated
//   frame_abort rx -> source : one-cycle pulse, frame dropped on timeout
//   busy        rx -> source : receiver is inside a frame
//
// master = frame source side, slave = receiver side.
// ---------------------------------------------------------------------------
interface nibble_parity_receiver_if;
    logic       start;
    logic       bit_in;
    logic       bit_valid;
    logic [3:0] data_out;
    logic       parity_out;
    logic       parity_err;
    logic       frame_valid;
    logic       frame_abort;
    logic       busy;

    modport master (
        output start, bit_in, bit_valid,
        input  data_out, parity_out, parity_err, frame_valid, frame_abort, busy
    );

    modport slave (
        input  start, bit_in, bit_valid,
        output data_out, parity_out, parity_err, frame_valid, frame_abort, busy
    );
endinterface

// File: rtl/nibble_parity_receiver.sv
// ---------------------------------------------------------------------------
// nibble_parity_receiver
// Collects a 4-bit serial nibble followed by one parity bit, regenerates the
// parity of the nibble and reports whether the received parity disagreed.
// The assembled nibble is presented on four parallel lines for the
// downstream 4-input parity gate stage.
//
// Parameters
//   ODD_PARITY : 1 = odd parity (expected bit = XNOR of data), 0 = even (XOR)
//   MSB_FIRST  : 1 = first data bit lands in data_out[3], 0 = in data_out[0]
//   TIMEOUT    : idle clocks tolerated between accepted bits (2..255)
//
// Ports
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : nibble_parity_receiver_if.slave (start/bit_in/bit_valid in,
//          data_out/parity_out/parity_err/frame_valid/frame_abort/busy out)
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module nibble_parity_receiver #(
    parameter int ODD_PARITY = 1,
    parameter int MSB_FIRST  = 1,
    parameter int TIMEOUT    = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    nibble_parity_receiver_if.slave         bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_PAR  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // The abort fires on the idle clock that would bring the count to
    // TIMEOUT, so the comparison is against TIMEOUT-1.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    // Expected parity bit for a nibble under the configured parity sense.
    function automatic logic f_parity(input logic [3:0] d);
        logic p;
        if (ODD_PARITY != 0) begin
            p = ~(^d);
        end else begin
            p = ^d;
        end
        return p;
    endfunction

    // Shift one serial bit into the nibble in the configured direction.
    function automatic logic [3:0] f_shift_in(input logic [3:0] cur, input logic b);
        logic [3:0] nxt;
        if (MSB_FIRST != 0) begin
            nxt = {cur[2:0], b};
        end else begin
            nxt = {b, cur[3:1]};
        end
        return nxt;
    endfunction

    state_t     r_state;
    logic [3:0] r_shift;
    logic [1:0] r_bit_cnt;
    logic [7:0] r_tmo_cnt;
    logic       r_rx_par;
    logic [3:0] r_data;
    logic       r_parity;
    logic       r_err;
    logic       r_fvalid;
    logic       r_fabort;
    logic       r_busy;

    state_t     w_state;
    logic [3:0] w_shift;
    logic [1:0] w_bit_cnt;
    logic [7:0] w_tmo_cnt;
    logic       w_rx_par;
    logic [3:0] w_data;
    logic       w_parity;
    logic       w_err;
    logic       w_fvalid;
    logic       w_fabort;
    logic       w_busy;

    // Next-state and next-output decode for the frame FSM.
    always_comb begin
        w_state   = r_state;
        w_shift   = r_shift;
        w_bit_cnt = r_bit_cnt;
        w_tmo_cnt = r_tmo_cnt;
        w_rx_par  = r_rx_par;
        w_data    = r_data;
        w_parity  = r_parity;
        w_err     = r_err;
        w_fvalid  = 1'b0;
        w_fabort  = 1'b0;

        case (r_state)
            S_IDLE: begin
                // bit_valid in the start cycle is deliberately not looked at.
                if (bus.start) begin
                    w_state   = S_DATA;
                    w_shift   = 4'b0000;
                    w_bit_cnt = 2'd0;
                    w_tmo_cnt = 8'd0;
                end else begin
                    w_state   = S_IDLE;
                end
            end

            S_DATA: begin
                if (bus.bit_valid) begin
                    w_shift   = f_shift_in(r_shift, bus.bit_in);
                    w_tmo_cnt = 8'd0;
                    if (r_bit_cnt == 2'd3) begin
                        w_state   = S_PAR;
                        w_bit_cnt = 2'd0;
                    end else begin
                        w_bit_cnt = r_bit_cnt + 2'd1;
                    end
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_state   = S_IDLE;
                    w_fabort  = 1'b1;
                    w_tmo_cnt = 8'd0;
                end else begin
                    w_tmo_cnt = r_tmo_cnt + 8'd1;
                end
            end

            S_PAR: begin
                if (bus.bit_valid) begin
                    w_rx_par  = bus.bit_in;
                    w_tmo_cnt = 8'd0;
                    w_state   = S_DONE;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_state   = S_IDLE;
                    w_fabort  = 1'b1;
                    w_tmo_cnt = 8'd0;
                end else begin
                    w_tmo_cnt = r_tmo_cnt + 8'd1;
                end
            end

            S_DONE: begin
                // Parity is regenerated from the data nibble only.
                w_fvalid = 1'b1;
                w_data   = r_shift;
                w_parity = f_parity(r_shift);
                w_err    = r_rx_par ^ f_parity(r_shift);
                w_state  = S_IDLE;
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase

        // busy is registered from the next state so it tracks the state flop.
        w_busy = (w_state != S_IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_shift   <= 4'b0000;
            r_bit_cnt <= 2'd0;
            r_tmo_cnt <= 8'd0;
            r_rx_par  <= 1'b0;
            r_data    <= 4'b0000;
            r_parity  <= f_parity(4'b0000);
            r_err     <= 1'b0;
            r_fvalid  <= 1'b0;
            r_fabort  <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_shift   <= w_shift;
            r_bit_cnt <= w_bit_cnt;
            r_tmo_cnt <= w_tmo_cnt;
            r_rx_par  <= w_rx_par;
            r_data    <= w_data;
            r_parity  <= w_parity;
            r_err     <= w_err;
            r_fvalid  <= w_fvalid;
            r_fabort  <= w_fabort;
            r_busy    <= w_busy;
        end
    end

    assign bus.data_out    = r_data;
    assign bus.parity_out  = r_parity;
    assign bus.parity_err  = r_err;
    assign bus.frame_valid = r_fvalid;
    assign bus.frame_abort = r_fabort;
    assign bus.busy        = r_busy;

endmodule

// File: tb/tb_nibble_parity_receiver.sv
// ---------------------------------------------------------------------------
// tb_nibble_parity_receiver
// Three receivers with different parameter sets are driven one at a time.
//   dut0 : odd parity, MSB first, TIMEOUT=16 (defaults)
//   dut1 : odd parity, LSB first, TIMEOUT=4
//   dut2 : even parity, MSB first, TIMEOUT=5
// Expected results come from a frame-level model: nibble assembled by bit
// position arithmetic, parity from the count of ones, abort whenever an idle
// gap reaches the timeout.
// ---------------------------------------------------------------------------
module tb_nibble_parity_receiver;

    logic       clk;
    logic       rst;
    logic [2:0] drv_start;
    logic [2:0] drv_bit;
    logic [2:0] drv_valid;

    int n_total;
    int n_bad;

    logic [3:0] exp_data [3];
    logic       exp_par  [3];
    logic       exp_err  [3];

    nibble_parity_receiver_if if0 ();
    nibble_parity_receiver_if if1 ();
    nibble_parity_receiver_if if2 ();

    assign if0.start     = drv_start[0];
    assign if0.bit_in    = drv_bit[0];
    assign if0.bit_valid = drv_valid[0];
    assign if1.start     = drv_start[1];
    assign if1.bit_in    = drv_bit[1];
    assign if1.bit_valid = drv_valid[1];
    assign if2.start     = drv_start[2];
    assign if2.bit_in    = drv_bit[2];
    assign if2.bit_valid = drv_valid[2];

    nibble_parity_receiver dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    nibble_parity_receiver #(.ODD_PARITY(1), .MSB_FIRST(0), .TIMEOUT(4))
        dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    nibble_parity_receiver #(.ODD_PARITY(0), .MSB_FIRST(1), .TIMEOUT(5))
        dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cfg_odd(input int k);
        return (k == 2) ? 0 : 1;
    endfunction
    function automatic int cfg_msb(input int k);
        return (k == 1) ? 0 : 1;
    endfunction
    function automatic int cfg_to(input int k);
        return (k == 0) ? 16 : ((k == 1) ? 4 : 5);
    endfunction

    function automatic logic [7:0] get_out(input int k, input int sel);
        logic [7:0] v;
        v = 8'd0;
        case (k)
            0: case (sel)
                   0: v = {4'd0, if0.data_out};
                   1: v = {7'd0, if0.parity_out};
                   2: v = {7'd0, if0.parity_err};
                   3: v = {7'd0, if0.frame_valid};
                   4: v = {7'd0, if0.frame_abort};
                   default: v = {7'd0, if0.busy};
               endcase
            1: case (sel)
                   0: v = {4'd0, if1.data_out};
                   1: v = {7'd0, if1.parity_out};
                   2: v = {7'd0, if1.parity_err};
                   3: v = {7'd0, if1.frame_valid};
                   4: v = {7'd0, if1.frame_abort};
                   default: v = {7'd0, if1.busy};
               endcase
            default: case (sel)
                   0: v = {4'd0, if2.data_out};
                   1: v = {7'd0, if2.parity_out};
                   2: v = {7'd0, if2.parity_err};
                   3: v = {7'd0, if2.frame_valid};
                   4: v = {7'd0, if2.frame_abort};
                   default: v = {7'd0, if2.busy};
               endcase
        endcase
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int k, input int sel, input logic [7:0] exp);
        logic [7:0] obs;
        obs = get_out(k, sel);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    // status: busy and the two pulses
    task automatic chk_status(input string tag, input int k, input logic b, input logic fv, input logic fa);
        chk({tag, "_busy"}, k, 5, {7'd0, b});
        chk({tag, "_fvalid"}, k, 3, {7'd0, fv});
        chk({tag, "_fabort"}, k, 4, {7'd0, fa});
    endtask

    task automatic chk_results(input string tag, input int k);
        chk({tag, "_data"}, k, 0, {4'd0, exp_data[k]});
        chk({tag, "_parity"}, k, 1, {7'd0, exp_par[k]});
        chk({tag, "_err"}, k, 2, {7'd0, exp_err[k]});
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            exp_data[k] = 4'd0;
            exp_par[k]  = (cfg_odd(k) != 0) ? 1'b1 : 1'b0;
            exp_err[k]  = 1'b0;
        end
    endtask

    task automatic idle(input int k, input int n);
        drv_start[k] = 1'b0;
        drv_valid[k] = 1'b0;
        for (int j = 0; j < n; j++) begin
            drv_bit[k] = 1'($urandom);
            tick();
            chk_status("idle", k, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // seq[3] is sent first; gaps[i] = idle clocks before bit i (i=4 is parity)
    task automatic send_frame(input int k, input logic [3:0] seq, input logic par,
                              input logic [4:0][7:0] gaps, input logic rep, input logic sv);
        int to;
        int abort_at;
        int g;
        int ones;
        int nib;
        int pos;
        logic ep;
        to       = cfg_to(k);
        abort_at = -1;
        for (int i = 0; i < 5; i++) begin
            if (abort_at < 0 && int'(gaps[i]) >= to) abort_at = i;
        end

        drv_start[k] = 1'b1;
        drv_valid[k] = sv;
        drv_bit[k]   = 1'b1;
        tick();
        drv_start[k] = rep;
        drv_valid[k] = 1'b0;
        chk_status("start", k, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 5; i++) begin
            g = (i == abort_at) ? to : int'(gaps[i]);
            for (int j = 0; j < g; j++) begin
                drv_valid[k] = 1'b0;
                drv_bit[k]   = 1'($urandom);
                tick();
                if (i == abort_at && j == g - 1) begin
                    chk_status("abort", k, 1'b0, 1'b0, 1'b1);
                    chk_results("abort_hold", k);
                    drv_start[k] = 1'b0;
                    drv_valid[k] = 1'b0;
                    return;
                end else begin
                    chk_status("gap", k, 1'b1, 1'b0, 1'b0);
                end
            end
            drv_valid[k] = 1'b1;
            drv_bit[k]   = (i < 4) ? seq[3 - i] : par;
            tick();
            chk_status("bit", k, 1'b1, 1'b0, 1'b0);
        end

        // DONE cycle: start and bit_valid here must be ignored
        drv_valid[k] = rep;
        drv_start[k] = rep;
        drv_bit[k]   = 1'b1;
        tick();

        nib  = 0;
        ones = 0;
        for (int i = 0; i < 4; i++) begin
            pos = (cfg_msb(k) != 0) ? (3 - i) : i;
            if (seq[3 - i]) begin
                nib  = nib + (1 << pos);
                ones = ones + 1;
            end
        end
        if (cfg_odd(k) != 0) ep = ((ones % 2) == 0);
        else                 ep = ((ones % 2) == 1);
        exp_data[k] = 4'(nib);
        exp_par[k]  = ep;
        exp_err[k]  = (par != ep);

        chk_status("done", k, 1'b0, 1'b1, 1'b0);
        chk_results("done", k);
        drv_start[k] = 1'b0;
        drv_valid[k] = 1'b0;
    endtask

    initial begin
        logic [4:0][7:0] gz;
        logic [4:0][7:0] gr;
        int k;
        int to;
        n_total   = 0;
        n_bad     = 0;
        drv_start = 3'b000;
        drv_bit   = 3'b000;
        drv_valid = 3'b000;
        gz        = '0;
        rst       = 1'b1;
        model_reset();
        #12;
        rst = 1'b0;
        tick();
        for (int d = 0; d < 3; d++) begin
            chk_status("reset", d, 1'b0, 1'b0, 1'b0);
            chk_results("reset", d);
        end

        // good frame and bad parity, defaults
        send_frame(0, 4'b1011, 1'b0, gz, 1'b0, 1'b0);
        idle(0, 2);
        send_frame(0, 4'b0110, 1'b0, gz, 1'b0, 1'b0);
        idle(0, 1);

        // LSB first
        send_frame(1, 4'b1000, 1'b0, gz, 1'b0, 1'b0);
        idle(1, 1);

        // timeout after two bits: four idle clocks abort
        gr = '0;
        gr[2] = 8'd4;
        send_frame(1, 4'b1100, 1'b1, gr, 1'b0, 1'b0);
        idle(1, 2);
        // bit arriving on the clock that would have been the 4th idle one
        gr[2] = 8'd3;
        send_frame(1, 4'b1101, 1'b1, gr, 1'b0, 1'b0);
        idle(1, 1);
        // timeout while waiting for the parity bit
        gr = '0;
        gr[4] = 8'd4;
        send_frame(1, 4'b0011, 1'b1, gr, 1'b0, 1'b0);
        idle(1, 1);

        // start held through the frame, bit_valid together with start
        send_frame(0, 4'b1110, 1'b1, gz, 1'b1, 1'b1);
        idle(0, 1);

        // back-to-back frames
        send_frame(0, 4'b0101, 1'b1, gz, 1'b0, 1'b0);
        send_frame(0, 4'b1001, 1'b0, gz, 1'b0, 1'b0);
        idle(0, 1);

        // even parity
        send_frame(2, 4'b0111, 1'b1, gz, 1'b0, 1'b0);
        idle(2, 1);

        // asynchronous reset in the middle of a frame
        drv_start[0] = 1'b1;
        tick();
        drv_start[0] = 1'b0;
        drv_valid[0] = 1'b1;
        drv_bit[0]   = 1'b1;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        for (int d = 0; d < 3; d++) begin
            chk_status("async_rst", d, 1'b0, 1'b0, 1'b0);
            chk_results("async_rst", d);
        end
        drv_valid[0] = 1'b0;
        tick();
        rst = 1'b0;
        idle(0, 2);
        chk_results("post_rst", 0);

        // randomized frames
        for (int n = 0; n < 40; n++) begin
            k  = int'($urandom_range(0, 2));
            to = cfg_to(k);
            for (int i = 0; i < 5; i++) begin
                if ($urandom_range(0, 7) == 0) gr[i] = 8'($urandom_range(to - 1, to));
                else                           gr[i] = 8'($urandom_range(0, 2));
            end
            send_frame(k, 4'($urandom), 1'($urandom), gr,
                       1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
            idle(k, int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/nibble_parity_receiver.md
# nibble_parity_receiver

Serial-input frame receiver that collects a 4-bit data nibble plus one parity bit. It regenerates the parity of the nibble and flags any mismatch with the received parity bit. It sits directly upstream of the 4-input parity (XNOR) gate stage and presents the assembled nibble as four parallel lines for that gate to consume. It also provides a registered in-block parity check, so the downstream stage and the check agree bit-for-bit.

## Interface
- ODD_PARITY, default 1: 1 = odd parity (expected parity bit = XNOR of the 4 data bits); 0 = even parity (expected = XOR).
- MSB_FIRST, default 1: 1 = first data bit lands in data_out[3]; 0 = first data bit lands in data_out[0].
- TIMEOUT, default 16: maximum idle clocks allowed between accepted bits inside a frame. Legal range 2..255.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a frame; sampled only in IDLE.
- bit_in  in  1  serial data/parity bit; sampled only when bit_valid=1.
- bit_valid  in  1  qualifies bit_in for one clock.
- data_out  out  4  last completed nibble; held between frames.
- parity_out  out  1  parity bit regenerated from data_out per ODD_PARITY.
- parity_err  out  1  1 = received parity bit differed from regenerated parity on the last completed frame.
- frame_valid  out  1  one-cycle pulse: data_out, parity_out and parity_err have just been updated.
- frame_abort  out  1  one-cycle pulse: a frame was dropped because of TIMEOUT.
- busy  out  1  1 in every state except IDLE.

## Operation
- States: IDLE, DATA, PAR, DONE.
- IDLE: start=1 -> DATA. The bit counter, shift register and timeout counter are cleared. bit_valid in the same cycle as start is ignored.
- DATA: each bit_valid=1 shifts bit_in into the internal shift register in the direction set by MSB_FIRST. After the 4th accepted bit -> PAR.
- PAR: the next bit_valid=1 captures the received parity bit -> DONE.
- DONE (one cycle):
  - frame_valid=1.
  - data_out <= shift register.
  - parity_out <= regenerated parity.
  - parity_err <= received bit XOR regenerated parity.
  - Then -> IDLE.
- Timeout:
  - The counter runs in DATA and PAR and resets to 0 on every accepted bit.
  - When it reaches TIMEOUT, frame_abort pulses for one cycle and the state returns to IDLE.
  - data_out, parity_out and parity_err keep their previous values.
  - A bit_valid arriving in the same cycle the count reaches TIMEOUT is accepted, and no abort occurs.
- start is ignored in DATA, PAR and DONE. It is honoured again from the first IDLE cycle.
- bit_valid in IDLE or DONE is ignored.
- frame_valid and frame_abort are never high together.
- Regenerated parity is always computed over the 4 captured data bits only, never over the parity bit.

## Timing
- Reset values:
  - state = IDLE.
  - data_out = 4'b0000.
  - parity_out = 1 if ODD_PARITY else 0, which keeps it consistent with data_out = 0.
  - parity_err, frame_valid, frame_abort and busy = 0.
- rst asserted mid-frame clears everything immediately (asynchronous). The partial frame is discarded with no pulse.
- busy goes high the cycle after start is sampled.
- Latency: frame_valid rises exactly one clock after the edge that samples the parity bit.
- Minimum frame length: 1 (start) + 5 (bits) + 1 (DONE) = 7 clocks, with bits on consecutive cycles.
- A new start is accepted no earlier than the cycle after DONE (back-to-back frames every 7 clocks).
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset: apply rst mid-operation, then release -> data_out=0000, parity_err=0, busy=0, no pulses.
- Good frame, default params: start, then bits 1,0,1,1 and parity bit 0 on consecutive cycles -> frame_valid pulse 1 clock after the parity bit, data_out=1011, parity_out=0, parity_err=0.
- Bad parity: start, bits 0,1,1,0, parity bit 0 -> data_out=0110, parity_out=1, parity_err=1.
- Bit ordering: MSB_FIRST=0, bits 1,0,0,0, parity bit 0 -> data_out=0001, parity_err=0.
- Timeout: TIMEOUT=4, start, bits 1,1, then no bit_valid for 4 clocks -> one frame_abort pulse, busy=0, data_out unchanged from the previous frame. A bit arriving exactly on the 4th idle clock instead -> no abort.
- Protocol corners:
  - start asserted repeatedly during a frame -> frame unaffected.
  - start and bit_valid in the same IDLE cycle -> that bit is not counted.
  - Back-to-back frames 7 clocks apart -> two frame_valid pulses with correct data each.
